// File: rtl/hidden_mem_sched.sv
// Read/write sequencer for one direction of the hidden-state memory: per timestep, sweeps h(t-1)
// over four read ports, then accepts h(t) words into the write port. Optional macro: HMEM_SCHED_OVERLAP_EN.
module hidden_mem_sched #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WORDS  = 50,
    parameter int NUM_STEPS  = 10,
    localparam int PW = ADDR_WIDTH - 1,
    localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          rd_en_1,
    output logic          rd_en_2,
    output logic          rd_en_3,
    output logic          rd_en_4,
    output logic [PW-1:0] rd_ptr_1,
    output logic [PW-1:0] rd_ptr_2,
    output logic [PW-1:0] rd_ptr_3,
    output logic [PW-1:0] rd_ptr_4,
    output logic          rd_group_valid,
    output logic          rd_group_last,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr,
    output logic [SW-1:0] step_idx,
    output logic          step_done,
    output logic          seq_done
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [ADDR_WIDTH-1:0] NW = ADDR_WIDTH'(NUM_WORDS);

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [SW-1:0]         step_idx_reg;
    logic                  group_valid_reg;
    logic                  group_last_reg;

    logic [ADDR_WIDTH-1:0] word [4];
    logic [3:0]            en_vec;
    logic [PW-1:0]         ptr_vec [4];
    logic                  last_group;
    logic                  final_write;

    // Per-port word index of the group being issued; disabled ports park their pointer at 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_port
            assign word[gi]    = base_reg + ADDR_WIDTH'(gi);
            assign en_vec[gi]  = (state_reg == READ) && (word[gi] < NW);
            assign ptr_vec[gi] = en_vec[gi] ? word[gi][PW-1:0] : '0;
        end
    endgenerate

    assign rd_en_1  = en_vec[0];
    assign rd_en_2  = en_vec[1];
    assign rd_en_3  = en_vec[2];
    assign rd_en_4  = en_vec[3];
    assign rd_ptr_1 = ptr_vec[0];
    assign rd_ptr_2 = ptr_vec[1];
    assign rd_ptr_3 = ptr_vec[2];
    assign rd_ptr_4 = ptr_vec[3];

    assign last_group = (state_reg == READ) && (base_reg + ADDR_WIDTH'(4) >= NW);

`ifdef HMEM_SCHED_OVERLAP_EN
    // Words below the group now being issued have already been read and may be overwritten.
    assign wr_ready = (state_reg == WRITE) || ((state_reg == READ) && (wr_ptr_reg < base_reg));
`else
    assign wr_ready = (state_reg == WRITE);
`endif

    assign wr_en          = wr_valid & wr_ready;
    assign wr_addr        = wr_ptr_reg[PW-1:0];
    assign final_write    = wr_en && (state_reg == WRITE) && (wr_ptr_reg == NW - 1'b1);
    assign step_done      = final_write;
    assign seq_done       = final_write && (step_idx_reg == SW'(NUM_STEPS - 1));
    assign step_idx       = step_idx_reg;
    assign busy           = (state_reg != IDLE);
    assign rd_group_valid = group_valid_reg;
    assign rd_group_last  = group_last_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            base_reg        <= '0;
            wr_ptr_reg      <= '0;
            step_idx_reg    <= '0;
            group_valid_reg <= 1'b0;
            group_last_reg  <= 1'b0;
        end else begin
            group_valid_reg <= en_vec[0];
            group_last_reg  <= last_group;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= READ;
                        base_reg   <= '0;
                        wr_ptr_reg <= '0;
                    end
                end
                READ: begin
                    base_reg <= base_reg + ADDR_WIDTH'(4);
                    if (last_group) begin
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    if (final_write) begin
                        state_reg    <= IDLE;
                        step_idx_reg <= (step_idx_reg == SW'(NUM_STEPS - 1)) ? '0 : step_idx_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_mem_sched.sv
// Scoreboard bench for hidden_mem_sched (NUM_WORDS=50, NUM_STEPS=2): stimulus queues expected
// read groups, group flags and write beats; a negedge monitor pops and compares them.
module tb_hidden_mem_sched;

    localparam int AW = 8;
    localparam int NW = 50;
    localparam int NS = 2;
    localparam int PW = AW - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          rd_en_1, rd_en_2, rd_en_3, rd_en_4;
    logic [PW-1:0] rd_ptr_1, rd_ptr_2, rd_ptr_3, rd_ptr_4;
    logic          rd_group_valid, rd_group_last;
    logic          wr_valid, wr_ready, wr_en;
    logic [PW-1:0] wr_addr;
    logic [0:0]    step_idx;
    logic          step_done, seq_done;

    hidden_mem_sched #(.ADDR_WIDTH(AW), .NUM_WORDS(NW), .NUM_STEPS(NS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .rd_en_1(rd_en_1), .rd_en_2(rd_en_2), .rd_en_3(rd_en_3), .rd_en_4(rd_en_4),
        .rd_ptr_1(rd_ptr_1), .rd_ptr_2(rd_ptr_2), .rd_ptr_3(rd_ptr_3), .rd_ptr_4(rd_ptr_4),
        .rd_group_valid(rd_group_valid), .rd_group_last(rd_group_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .step_idx(step_idx), .step_done(step_done), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q [$];
    logic        grp_q [$];
    logic [9:0]  wr_q [$];

    logic [31:0] mon_rd;
    logic [9:0]  mon_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // Expected read group g: ports k=0..3 address 4g+k, enabled while below NW, pointer 0 when disabled.
    task automatic push_reads(input int nrd, input int ngrp);
        logic [31:0] rec;
        int w;
        for (int g = 0; g < nrd; g++) begin
            rec = '0;
            for (int k = 0; k < 4; k++) begin
                w = 4 * g + k;
                if (w < NW) begin
                    rec[28 + k]      = 1'b1;
                    rec[7*k +: 7]    = 7'(w);
                end
            end
            rd_q.push_back(rec);
        end
        for (int g = 0; g < ngrp; g++) grp_q.push_back(g == 12);
    endtask

    task automatic push_writes(input logic idx, input logic seq);
        for (int i = 0; i < NW; i++)
            wr_q.push_back({7'(i), (i == NW - 1), seq && (i == NW - 1), idx});
    endtask

    task automatic check_drained(input string tag);
        check({tag, " rd_q empty"}, rd_q.size(), 0);
        check({tag, " grp_q empty"}, grp_q.size(), 0);
        check({tag, " wr_q empty"}, wr_q.size(), 0);
    endtask

    task automatic do_step(input bit gapped, input logic exp_next);
        bit done;
        start = 1'b1;
        @(posedge clk); #1;
        check("busy after start", busy, 1);
`ifdef HMEM_SCHED_OVERLAP_EN
        wr_valid = 1'b1;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 2; c <= 13; c++) begin
            check("busy in read", busy, 1);
`ifndef HMEM_SCHED_OVERLAP_EN
            check("wr_ready low in read", wr_ready, 0);
`endif
            @(posedge clk); #1;
        end
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            wr_valid = gapped ? (c % 2 == 0) : 1'b1;
            @(negedge clk);
            if (step_done) done = 1'b1;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        check("step_done seen", done, 1);
        check("busy falls after final write", busy, 0);
        check("step_idx after step", step_idx, exp_next);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en_1 | rd_en_2 | rd_en_3 | rd_en_4) begin
                if (rd_q.size() == 0) check("unexpected read group", 1, 0);
                else begin
                    mon_rd = rd_q.pop_front();
                    $display("rd en=%b ptrs=%0d,%0d,%0d,%0d", {rd_en_4, rd_en_3, rd_en_2, rd_en_1},
                             rd_ptr_1, rd_ptr_2, rd_ptr_3, rd_ptr_4);
                    check("read group", {rd_en_4, rd_en_3, rd_en_2, rd_en_1,
                                         rd_ptr_4, rd_ptr_3, rd_ptr_2, rd_ptr_1}, mon_rd);
                end
            end
            if (rd_group_valid) begin
                if (grp_q.size() == 0) check("unexpected rd_group_valid", 1, 0);
                else begin
                    $display("grp valid last=%b", rd_group_last);
                    check("rd_group_last", rd_group_last, grp_q.pop_front());
                end
            end else if (rd_group_last) begin
                check("rd_group_last without valid", 1, 0);
            end
            if (wr_en) begin
                if (wr_q.size() == 0) check("unexpected write", 1, 0);
                else begin
                    mon_wr = wr_q.pop_front();
                    $display("wr addr=%0d done=%b seq=%b idx=%0d", wr_addr, step_done, seq_done, step_idx);
                    check("write beat", {wr_addr, step_done, seq_done, step_idx}, mon_wr);
                end
            end else if (step_done | seq_done) begin
                check("done pulse without write", 1, 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        wr_valid = 1'b0;
        #3;
        check("reset busy", busy, 0);
        check("reset rd_en_1", rd_en_1, 0);
        check("reset rd_group_valid", rd_group_valid, 0);
        check("reset wr_ready", wr_ready, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset step_idx", step_idx, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // wr_valid while idle must not produce a write
        wr_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("wr_ready idle", wr_ready, 0);
        wr_valid = 1'b0;

        // Step A: continuous writes, idx 0 -> 1
        push_reads(13, 13);
        push_writes(1'b0, 1'b0);
        do_step(1'b0, 1'b1);
        check_drained("step A");

        // Step C: reset in READ cycle 5, step abandoned
        push_reads(4, 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset busy", busy, 0);
        check("async reset rd_en_1", rd_en_1, 0);
        check("async reset rd_ptr_2", rd_ptr_2, 0);
        check("async reset rd_group_valid", rd_group_valid, 0);
        check("async reset step_idx", step_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_drained("abort");

        // Step D: gapped writes, idx 0 -> 1, restarts at ptr 0
        push_reads(13, 13);
        push_writes(1'b0, 1'b0);
        do_step(1'b1, 1'b1);
        check_drained("step D");

        // Step E: final step of sequence, seq_done with step_done, idx wraps to 0
        push_reads(13, 13);
        push_writes(1'b1, 1'b1);
        do_step(1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_drained("step E");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
